// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence detector.
// A DATA_W-bit word is taken through a valid/ready handshake and shifted
// out one bit per DIV-clock bit period on o_seq. o_enable is a one-cycle
// strobe in the last clock of each bit period, aligned with o_seq.
// All outputs are decoded from registered state only.
module seq_serializer #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_seq,
  output logic              o_enable,
  output logic              o_busy,
  output logic              o_done
);

  // Divider needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CW = $clog2(DATA_W);

  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [DIV_CW-1:0] div_cnt_reg;
  logic [DIV_CW-1:0] div_cnt_next;
  logic [BIT_CW-1:0] bit_cnt_reg;
  logic [BIT_CW-1:0] bit_cnt_next;

  logic [DATA_W-1:0] shifted;
  logic              head_bit;
  logic              strobe;
  logic              last_bit;
  logic              ready_int;
  logic              xfer;

  // Shift network: the word moves toward the transmit end, a zero fills in.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == DATA_W - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end

    if (MSB_FIRST != 0) begin : g_head_msb
      assign head_bit = shift_reg[DATA_W-1];
    end else begin : g_head_lsb
      assign head_bit = shift_reg[0];
    end
  endgenerate

  // Strobe fires in the final clock of each bit period while shifting.
  assign strobe    = (state_reg == ST_SHIFT) && (div_cnt_reg == DIV_LAST);
  // The last-bit strobe cycle doubles as the slot for the next word.
  assign last_bit  = strobe && (bit_cnt_reg == BIT_LAST);
  assign ready_int = (state_reg == ST_IDLE) || last_bit;
  assign xfer      = i_valid && ready_int;

  // Next-state logic for the FSM, divider, bit counter and shift register.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (xfer) begin
          shift_next   = i_data;
          div_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (strobe) begin
          div_cnt_next = '0;
          if (last_bit) begin
            bit_cnt_next = '0;
            if (xfer) begin
              // Back-to-back word: reload with no idle gap.
              shift_next = i_data;
              state_next = ST_SHIFT;
            end else begin
              shift_next = '0;
              state_next = ST_IDLE;
            end
          end else begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + BIT_CW'(1);
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_CW'(1);
        end
      end
      default: begin
        state_next   = ST_IDLE;
        shift_next   = '0;
        div_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    o_ready  = ready_int;
    o_enable = strobe;
    o_done   = last_bit;
    o_busy   = (state_reg == ST_SHIFT);
    o_seq    = (state_reg == ST_SHIFT) && head_bit;
  end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: table vectors, hand-written corner sequences and
// randomized traffic on three serializer instances, every output checked
// each cycle against a timing/bit model derived from the accept edge.
module tb_seq_serializer;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       valid_v [3];
  logic       ready_v [3];
  logic       seq_v   [3];
  logic       en_v    [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] data_v  [3];

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  // Edge counter: after k rising edges cyc==k, so the next edge is cyc+1.
  always @(posedge clk) cyc <= cyc + 1;

  seq_serializer #(.DATA_W(8), .DIV(4), .MSB_FIRST(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_v[0]), .i_valid(valid_v[0]),
    .o_ready(ready_v[0]), .o_seq(seq_v[0]), .o_enable(en_v[0]),
    .o_busy(busy_v[0]), .o_done(done_v[0]));

  seq_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(1)) u_div1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_v[1]), .i_valid(valid_v[1]),
    .o_ready(ready_v[1]), .o_seq(seq_v[1]), .o_enable(en_v[1]),
    .o_busy(busy_v[1]), .o_done(done_v[1]));

  seq_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_v[2]), .i_valid(valid_v[2]),
    .o_ready(ready_v[2]), .o_seq(seq_v[2]), .o_enable(en_v[2]),
    .o_busy(busy_v[2]), .o_done(done_v[2]));

  int div_p [3] = '{4, 1, 1};
  bit msb_p [3] = '{1'b1, 1'b1, 1'b0};

  // Reference model: last accepted word and its accept edge per instance.
  bit         have_w [3];
  longint     acc_e  [3];
  logic [7:0] mword  [3];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 60) $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc + 1);
    end
  endtask

  // One model step per instance, evaluated on the falling edge.
  task automatic model_step(input int i);
    longint     n;
    longint     d;
    longint     span;
    int         j;
    logic [7:0] w;
    logic       e_rdy, e_seq, e_en, e_busy, e_done;
    n    = cyc + 1;
    span = longint'(DW * div_p[i]);
    e_seq = 1'b0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
    if (!rst_n) begin
      have_w[i] = 1'b0;
    end else if (have_w[i]) begin
      d      = n - acc_e[i];
      e_busy = (d >= 1) && (d <= span);
      e_rdy  = !e_busy || (d == span);
      if (e_busy) begin
        e_en   = ((d % div_p[i]) == 0);
        e_done = e_en && (d == span);
        j      = int'((d - 1) / div_p[i]);
        w      = mword[i];
        e_seq  = msb_p[i] ? w[DW-1-j] : w[j];
      end
    end
    chk($sformatf("dut%0d_ready", i), longint'(ready_v[i]), longint'(e_rdy));
    chk($sformatf("dut%0d_busy", i), longint'(busy_v[i]), longint'(e_busy));
    chk($sformatf("dut%0d_enable", i), longint'(en_v[i]), longint'(e_en));
    chk($sformatf("dut%0d_done", i), longint'(done_v[i]), longint'(e_done));
    chk($sformatf("dut%0d_seq", i), longint'(seq_v[i]), longint'(e_seq));
    if (rst_n && valid_v[i] && e_rdy) begin
      have_w[i] = 1'b1;
      acc_e[i]  = n;
      mword[i]  = data_v[i];
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the handshake with valid already driven.
  task automatic wait_accept(input int i, output longint e);
    e = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready_v[i] && valid_v[i]) begin
        e = cyc + 1;
        break;
      end
    end
    if (e < 0) chk($sformatf("dut%0d_accept_timeout", i), 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] w, output longint e);
    data_v[i]  = w;
    valid_v[i] = 1'b1;
    wait_accept(i, e);
    valid_v[i] = 1'b0;
    $display("xfer dut%0d word=%h accept_edge=%0d", i, w, e);
  endtask

  // Collect nbits strobed bits; also feed a "101" detector over them.
  task automatic collect(input int i, input int nbits, output logic [15:0] bits,
                         output logic [15:0] dmask, output int ndone,
                         output longint first_e, output longint last_e,
                         output int gap_bad);
    int         got;
    longint     prev;
    longint     n;
    logic [2:0] hist;
    bits = '0; dmask = '0; ndone = 0; first_e = -1; last_e = -1; gap_bad = 0;
    got = 0; prev = -1; hist = '0;
    for (int k = 0; k < nbits * div_p[i] + 20 && got < nbits; k++) begin
      @(negedge clk);
      if (en_v[i]) begin
        n     = cyc + 1;
        bits  = {bits[14:0], seq_v[i]};
        hist  = {hist[1:0], seq_v[i]};
        dmask = {dmask[14:0], (hist == 3'b101)};
        if (done_v[i]) ndone++;
        if (prev >= 0 && n - prev != longint'(div_p[i])) gap_bad++;
        if (got == 0) first_e = n;
        last_e = n;
        prev   = n;
        got++;
      end
    end
    if (got < nbits) chk($sformatf("dut%0d_strobe_timeout", i), got, nbits);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         inst;
    logic [7:0] word;
    logic [7:0] exp_bits;
    logic [7:0] exp_det;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint     e, e2, acc;
    logic [15:0] bits, dmask;
    int         ndone, gap_bad, ecount;
    longint     fe, le;
    logic [7:0] fin;

    // Bits listed first-sent in the MSB; detector mask marks the bit
    // positions after which "101" has just been seen.
    vecs[0] = '{0, 8'hB0, 8'hB0, 8'h20};
    vecs[1] = '{0, 8'hA5, 8'hA5, 8'h21};
    vecs[2] = '{0, 8'h0F, 8'h0F, 8'h00};
    vecs[3] = '{1, 8'h5A, 8'h5A, 8'h12};
    vecs[4] = '{2, 8'h5A, 8'h5A, 8'h12};
    vecs[5] = '{1, 8'hC3, 8'hC3, 8'h00};
    vecs[6] = '{2, 8'h01, 8'h80, 8'h00};
    vecs[7] = '{0, 8'h81, 8'h81, 8'h00};

    for (int i = 0; i < 3; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = 8'hC9;   // valid is low, so this must never be taken
    end

    // Reset held with valid low and high: outputs at reset values.
    tick(3);
    valid_v[0] = 1'b1;
    @(negedge clk);
    chk("reset_ready", longint'(ready_v[0]), 1);
    chk("reset_busy", longint'(busy_v[0]), 0);
    chk("reset_enable", longint'(en_v[0]), 0);
    chk("reset_seq", longint'(seq_v[0]), 0);
    tick(1);
    valid_v[0] = 1'b0;
    rst_n = 1'b1;
    ecount = 0;
    repeat (100) begin
      @(negedge clk);
      if (en_v[0]) ecount++;
    end
    chk("idle_no_strobe", ecount, 0);
    tick(1);

    // Single word: strobes at E+4..E+32, done at E+32 only, then idle.
    send(0, 8'hB0, e);
    collect(0, 8, bits, dmask, ndone, fe, le, gap_bad);
    chk("b0_bits", bits[7:0], 8'hB0);
    chk("b0_first_strobe", fe, e + 4);
    chk("b0_last_strobe", le, e + 32);
    chk("b0_gaps", gap_bad, 0);
    chk("b0_done_count", ndone, 1);
    @(negedge clk);
    chk("b0_idle_after", longint'(busy_v[0]), 0);
    tick(2);

    // Back-to-back words with valid held high.
    fork
      collect(0, 16, bits, dmask, ndone, fe, le, gap_bad);
      begin
        data_v[0]  = 8'hA5;
        valid_v[0] = 1'b1;
        wait_accept(0, e);
        data_v[0]  = 8'h0F;
        wait_accept(0, e2);
        valid_v[0] = 1'b0;
      end
    join
    $display("xfer dut0 words=a5,0f accept_edges=%0d,%0d", e, e2);
    chk("b2b_bits", bits, 16'hA50F);
    chk("b2b_second_accept", e2, e + 32);
    chk("b2b_last_strobe", le, e + 64);
    chk("b2b_gaps", gap_bad, 0);
    chk("b2b_done_count", ndone, 2);
    tick(3);

    // Valid raised mid-word with changing data: accepted only at E+32.
    send(0, 8'h3C, e);
    repeat (9) @(posedge clk);
    #1;
    valid_v[0] = 1'b1;
    data_v[0]  = 8'($urandom);
    acc = -1;
    fin = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_v[0]) begin
        acc = cyc + 1;
        fin = data_v[0];
        break;
      end
      @(posedge clk);
      #1;
      data_v[0] = 8'($urandom);
    end
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    $display("xfer dut0 word=%h accept_edge=%0d (held off)", fin, acc);
    chk("hold_accept_edge", acc, e + 32);
    collect(0, 8, bits, dmask, ndone, fe, le, gap_bad);
    chk("hold_bits", bits[7:0], fin);
    tick(2);

    // Table vectors.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].inst, vecs[v].word, e);
      collect(vecs[v].inst, 8, bits, dmask, ndone, fe, le, gap_bad);
      $display("vec %0d dut%0d word=%h bits=%b detect=%b", v, vecs[v].inst,
               vecs[v].word, bits[7:0], dmask[7:0]);
      chk($sformatf("vec%0d_bits", v), bits[7:0], vecs[v].exp_bits);
      chk($sformatf("vec%0d_detect", v), dmask[7:0], vecs[v].exp_det);
      chk($sformatf("vec%0d_done", v), ndone, 1);
      chk($sformatf("vec%0d_first_strobe", v), fe, e + div_p[vecs[v].inst]);
      tick(1);
    end

    // Reset after the third strobe of 8'hFF, then a fresh word.
    send(0, 8'hFF, e);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_busy", longint'(busy_v[0]), 0);
      chk("midreset_enable", longint'(en_v[0]), 0);
    end
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_enable", longint'(en_v[0]), 0);
    chk("release_busy", longint'(busy_v[0]), 0);
    tick(1);
    send(0, 8'h81, e);
    collect(0, 8, bits, dmask, ndone, fe, le, gap_bad);
    chk("after_reset_bits", bits[7:0], 8'h81);
    tick(2);

    // Randomized traffic, including back-to-back words and random resets.
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 40; w++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) tick(g);
        send(i, 8'($urandom), e);
        if ($urandom_range(0, 9) == 0) begin
          tick($urandom_range(1, 8 * div_p[i]));
          rst_n = 1'b0;
          tick(2);
          rst_n = 1'b1;
          $display("reset pulse during dut%0d traffic", i);
        end
      end
      tick(40);
    end

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
